inst_fetch_resp: RTL and testbench

- Responder side of the instruction-fetch interface driven by the PC stage (pc, ce).
- Accepts each new fetch address and issues a read to a synchronous instruction memory that has WAIT_STATES extra cycles of latency.
- Returns the instruction word to the IF/ID register and raises a stall request to ctrl while a fetch is outstanding.
- Squashes an in-flight fetch when ID resolves a taken branch.

---
 rtl/inst_fetch_resp_pkg.sv | 30 +++
 rtl/inst_fetch_resp.sv | 145 ++++++++++++++
 tb/tb_inst_fetch_resp.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_resp_pkg.sv
`default_nettype none
// inst_fetch_resp_pkg: shared constants, bus widths and FSM encoding for the IF fetch responder.
// Revision 1.0
package inst_fetch_resp_pkg;

  localparam logic C_RST_ENABLE   = 1'b0;
  localparam logic C_RST_DISABLE  = 1'b1;
  localparam logic C_CHIP_ENABLE  = 1'b1;
  localparam logic C_CHIP_DISABLE = 1'b0;
  localparam logic C_STOP         = 1'b1;
  localparam logic C_NO_STOP      = 1'b0;
  localparam logic C_BRANCH       = 1'b1;
  localparam logic C_NOT_BRANCH   = 1'b0;

  localparam int C_INST_ADDR_BUS_W = 32;
  localparam int C_INST_BUS_W      = 32;
  localparam int C_STALL_W         = 6;
  localparam int C_STALL_IFID_BIT  = 1;
  localparam int C_CNT_W           = 4;

  localparam logic [C_INST_BUS_W-1:0] C_NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_resp.sv
`default_nettype none
// inst_fetch_resp: accepts PC-stage fetches, reads a wait-stated sync ROM, returns the word to IF/ID.
// Revision 1.0
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce_i,
  input  logic [C_INST_ADDR_BUS_W-1:0] pc_i,
  input  logic [C_STALL_W-1:0]         stall_i,
  input  logic                         branch_flag_i,
  output logic                         mem_en_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  input  logic [C_INST_BUS_W-1:0]      mem_rdata_i,
  output logic [C_INST_BUS_W-1:0]      inst_o,
  output logic                         inst_valid_o,
  output logic                         stallreq_o,
  output logic                         addr_err_o
);

  localparam logic [C_CNT_W-1:0] C_WAIT_LOAD = C_CNT_W'(WAIT_STATES);

  fetch_state_e                   state_q, state_d;
  logic                           mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]              mem_addr_q, mem_addr_d;
  logic [C_INST_BUS_W-1:0]        inst_q, inst_d;
  logic                           inst_valid_q, inst_valid_d;
  logic                           addr_err_q, addr_err_d;
  logic [C_INST_ADDR_BUS_W-1:0]   last_pc_q, last_pc_d;
  logic                           last_valid_q, last_valid_d;
  logic                           kill_q, kill_d;
  logic [C_CNT_W-1:0]             cnt_q, cnt_d;
  logic                           new_req;
  logic                           branch;
  logic                           unused_ok;

  assign branch  = (branch_flag_i == C_BRANCH);
  assign new_req = (ce_i == C_CHIP_ENABLE) &&
                   (stall_i[C_STALL_IFID_BIT] == C_NO_STOP) &&
                   ((pc_i != last_pc_q) || !last_valid_q);

  // Only the IF/ID stall bit and the word-address bits within memory depth matter here.
  assign unused_ok = ^{stall_i[C_STALL_W-1:C_STALL_IFID_BIT+1], stall_i[0],
                       pc_i[C_INST_ADDR_BUS_W-1:ADDR_W+2]};

  always_ff @(posedge clk or negedge rst) begin
    if (rst == C_RST_ENABLE) begin
      state_q      <= IDLE;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      inst_q       <= C_NOP_INST;
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      last_pc_q    <= '0;
      last_valid_q <= 1'b0;
      kill_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      addr_err_q   <= addr_err_d;
      last_pc_q    <= last_pc_d;
      last_valid_q <= last_valid_d;
      kill_q       <= kill_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_en_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    addr_err_d   = 1'b0;
    last_pc_d    = last_pc_q;
    last_valid_d = last_valid_q;
    kill_d       = kill_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (ce_i == C_CHIP_DISABLE) begin
          inst_d       = C_NOP_INST;
          last_valid_d = 1'b0;
        end else if (new_req) begin
          last_pc_d    = pc_i;
          last_valid_d = 1'b1;
          if (pc_i[1:0] == 2'b00) begin
            mem_addr_d = pc_i[ADDR_W+1:2];
            mem_en_d   = 1'b1;
            state_d    = REQ;
          end else begin
            // Misaligned fetch: answer locally with a NOP, memory is never touched.
            addr_err_d   = 1'b1;
            inst_d       = C_NOP_INST;
            inst_valid_d = 1'b1;
          end
        end
      end

      REQ: begin
        cnt_d   = C_WAIT_LOAD;
        state_d = WAIT;
        if (branch) kill_d = 1'b1;
      end

      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (branch) kill_d = 1'b1;
        end else begin
          state_d = IDLE;
          // A branch arriving on the capture cycle still squashes the word.
          if (kill_q || branch) begin
            inst_d       = C_NOP_INST;
            kill_d       = 1'b0;
            last_valid_d = 1'b0;
          end else begin
            inst_d       = mem_rdata_i;
            inst_valid_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign mem_en_o     = mem_en_q;
  assign mem_addr_o   = mem_addr_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;
  assign addr_err_o   = addr_err_q;
  assign stallreq_o   = (state_q != IDLE) ? C_STOP : C_NO_STOP;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_resp.sv
`default_nettype none
// tb_inst_fetch_resp: two responders (WAIT_STATES=1 and 2) against a latency-exact ROM model.
module tb_inst_fetch_resp;

  localparam int AW   = 10;
  localparam int WS_A = 1;
  localparam int WS_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce, branch, sel;
  logic [31:0] pc;
  logic [5:0]  stall;
  logic [31:0] rom [1024];

  logic            a_ce, b_ce, a_br, b_br;
  logic            a_en, b_en, a_valid, b_valid, a_stall, b_stall, a_err, b_err;
  logic [AW-1:0]   a_addr, b_addr;
  logic [31:0]     a_rdata, b_rdata, a_inst, b_inst;

  // Only the selected responder sees ce/branch; the other idles with ce low.
  assign a_ce = ce & ~sel;
  assign b_ce = ce & sel;
  assign a_br = branch & ~sel;
  assign b_br = branch & sel;

  inst_fetch_resp #(.ADDR_W(AW), .WAIT_STATES(WS_A)) dut_a (
    .clk(clk), .rst(rst), .ce_i(a_ce), .pc_i(pc), .stall_i(stall), .branch_flag_i(a_br),
    .mem_en_o(a_en), .mem_addr_o(a_addr), .mem_rdata_i(a_rdata), .inst_o(a_inst),
    .inst_valid_o(a_valid), .stallreq_o(a_stall), .addr_err_o(a_err));

  inst_fetch_resp #(.ADDR_W(AW), .WAIT_STATES(WS_B)) dut_b (
    .clk(clk), .rst(rst), .ce_i(b_ce), .pc_i(pc), .stall_i(stall), .branch_flag_i(b_br),
    .mem_en_o(b_en), .mem_addr_o(b_addr), .mem_rdata_i(b_rdata), .inst_o(b_inst),
    .inst_valid_o(b_valid), .stallreq_o(b_stall), .addr_err_o(b_err));

  // ROM model: data is correct only exactly WS+1 cycles after the strobe cycle, garbage otherwise.
  int            a_age = 100, b_age = 100;
  logic [AW-1:0] a_raddr = '0, b_raddr = '0;
  always @(posedge clk) begin
    if (a_en) begin a_age <= 1; a_raddr <= a_addr; end
    else if (a_age < 100) a_age <= a_age + 1;
    if (b_en) begin b_age <= 1; b_raddr <= b_addr; end
    else if (b_age < 100) b_age <= b_age + 1;
  end
  assign a_rdata = (a_age == WS_A + 1) ? rom[a_raddr] : (rom[a_raddr] ^ 32'hA5A5_0F0F);
  assign b_rdata = (b_age == WS_B + 1) ? rom[b_raddr] : (rom[b_raddr] ^ 32'hA5A5_0F0F);

  logic          o_en, o_valid, o_stall, o_err;
  logic [AW-1:0] o_addr;
  logic [31:0]   o_inst;
  assign o_en    = sel ? b_en    : a_en;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_stall = sel ? b_stall : a_stall;
  assign o_err   = sel ? b_err   : a_err;
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_inst  = sel ? b_inst  : a_inst;

  int errors = 0;
  int checks = 0;

  int            n_en, n_valid, n_stall, n_err;
  logic [AW-1:0] en_addr;
  logic [31:0]   valid_inst, fall_inst;
  logic          fell, fall_valid, prev_stall;

  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    return AW'((a >> 2) % 32'd1024);
  endfunction

  task automatic clear_mon();
    n_en = 0; n_valid = 0; n_stall = 0; n_err = 0;
    en_addr = '0; valid_inst = '0; fall_inst = '0;
    fell = 1'b0; fall_valid = 1'b0; prev_stall = o_stall;
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (o_en)    begin n_en++; en_addr = o_addr; end
      if (o_valid) begin n_valid++; valid_inst = o_inst; end
      if (o_stall) n_stall++;
      if (o_err)   n_err++;
      if (prev_stall && !o_stall && !fell) begin
        fell = 1'b1; fall_inst = o_inst; fall_valid = o_valid;
      end
      prev_stall = o_stall;
    end
  endtask

  task automatic test_reset();
    checks++; if (o_en !== 1'b0)      begin errors++; $display("FAIL reset_en got %b want 0", o_en); end
    checks++; if (o_addr !== '0)      begin errors++; $display("FAIL reset_addr got %h want 0", o_addr); end
    checks++; if (o_inst !== 32'h0)   begin errors++; $display("FAIL reset_inst got %h want 0", o_inst); end
    checks++; if (o_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_stall !== 1'b0)   begin errors++; $display("FAIL reset_stall got %b want 0", o_stall); end
    checks++; if (o_err !== 1'b0)     begin errors++; $display("FAIL reset_err got %b want 0", o_err); end
    checks++; if (b_stall !== 1'b0)   begin errors++; $display("FAIL reset_stall_b got %b want 0", b_stall); end
  endtask

  task automatic test_basic();
    sel = 1'b0; clear_mon(); ce = 1'b1; pc = 32'h0; observe(8);
    checks++; if (n_en !== 1)      begin errors++; $display("FAIL basic_en_count got %0d want 1", n_en); end
    checks++; if (en_addr !== '0)  begin errors++; $display("FAIL basic_addr got %h want 0", en_addr); end
    checks++; if (n_stall !== 3)   begin errors++; $display("FAIL basic_stall_cycles got %0d want 3", n_stall); end
    checks++; if (n_valid !== 1)   begin errors++; $display("FAIL basic_valid_count got %0d want 1", n_valid); end
    checks++; if (valid_inst !== 32'h3C011234) begin errors++; $display("FAIL basic_inst got %h want 3c011234", valid_inst); end
    checks++; if (fall_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_at_release got %b want 1", fall_valid); end
    checks++; if (o_inst !== 32'h3C011234) begin errors++; $display("FAIL basic_inst_hold got %h want 3c011234", o_inst); end
  endtask

  task automatic test_hold_pc();
    sel = 1'b1; clear_mon(); pc = 32'h08; observe(12);
    checks++; if (n_en !== 1)        begin errors++; $display("FAIL hold_en_count got %0d want 1", n_en); end
    checks++; if (en_addr !== 10'd2) begin errors++; $display("FAIL hold_addr got %h want 2", en_addr); end
    checks++; if (n_stall !== 4)     begin errors++; $display("FAIL hold_stall_cycles got %0d want 4", n_stall); end
    checks++; if (o_inst !== rom[2]) begin errors++; $display("FAIL hold_inst got %h want %h", o_inst, rom[2]); end
  endtask

  task automatic test_branch_wait();
    sel = 1'b1; clear_mon(); pc = 32'h10; observe(2);
    branch = 1'b1; pc = 32'h40; observe(1);
    branch = 1'b0; observe(12);
    checks++; if (fall_inst !== 32'h0) begin errors++; $display("FAIL branch_drop_inst got %h want 0", fall_inst); end
    checks++; if (fall_valid !== 1'b0) begin errors++; $display("FAIL branch_drop_valid got %b want 0", fall_valid); end
    checks++; if (n_en !== 2)          begin errors++; $display("FAIL branch_en_count got %0d want 2", n_en); end
    checks++; if (en_addr !== 10'h10)  begin errors++; $display("FAIL branch_new_addr got %h want 10", en_addr); end
    checks++; if (n_valid !== 1)       begin errors++; $display("FAIL branch_valid_count got %0d want 1", n_valid); end
    checks++; if (n_stall !== 8)       begin errors++; $display("FAIL branch_stall_cycles got %0d want 8", n_stall); end
    checks++; if (o_inst !== rom[16])  begin errors++; $display("FAIL branch_new_inst got %h want %h", o_inst, rom[16]); end
  endtask

  task automatic test_branch_capture();
    sel = 1'b0; pc = 32'h48; observe(6);
    clear_mon(); pc = 32'h44; observe(3);
    branch = 1'b1; observe(1);
    branch = 1'b0; observe(8);
    checks++; if (fall_inst !== 32'h0) begin errors++; $display("FAIL capbr_drop_inst got %h want 0", fall_inst); end
    checks++; if (fall_valid !== 1'b0) begin errors++; $display("FAIL capbr_drop_valid got %b want 0", fall_valid); end
    checks++; if (n_en !== 2)          begin errors++; $display("FAIL capbr_refetch_count got %0d want 2", n_en); end
    checks++; if (n_valid !== 1)       begin errors++; $display("FAIL capbr_valid_count got %0d want 1", n_valid); end
    checks++; if (o_inst !== rom[17])  begin errors++; $display("FAIL capbr_inst got %h want %h", o_inst, rom[17]); end
  endtask

  task automatic test_misaligned();
    sel = 1'b0; clear_mon(); pc = 32'h06; observe(4);
    checks++; if (n_err !== 1)       begin errors++; $display("FAIL mis_err_count got %0d want 1", n_err); end
    checks++; if (n_valid !== 1)     begin errors++; $display("FAIL mis_valid_count got %0d want 1", n_valid); end
    checks++; if (o_inst !== 32'h0)  begin errors++; $display("FAIL mis_inst got %h want 0", o_inst); end
    checks++; if (n_en !== 0)        begin errors++; $display("FAIL mis_en_count got %0d want 0", n_en); end
    checks++; if (n_stall !== 0)     begin errors++; $display("FAIL mis_stall_cycles got %0d want 0", n_stall); end
  endtask

  task automatic test_stall_hold();
    sel = 1'b0; clear_mon(); pc = 32'h20; observe(6);
    checks++; if (o_inst !== rom[8]) begin errors++; $display("FAIL stall_pre_inst got %h want %h", o_inst, rom[8]); end
    clear_mon(); stall = 6'b000010; pc = 32'h24; observe(6);
    checks++; if (n_en !== 0)        begin errors++; $display("FAIL stall_en_count got %0d want 0", n_en); end
    checks++; if (n_valid !== 0)     begin errors++; $display("FAIL stall_valid_count got %0d want 0", n_valid); end
    checks++; if (o_inst !== rom[8]) begin errors++; $display("FAIL stall_inst_hold got %h want %h", o_inst, rom[8]); end
    clear_mon(); stall = 6'b0; observe(6);
    checks++; if (n_en !== 1)        begin errors++; $display("FAIL stall_rel_en_count got %0d want 1", n_en); end
    checks++; if (en_addr !== 10'd9) begin errors++; $display("FAIL stall_rel_addr got %h want 9", en_addr); end
    checks++; if (o_inst !== rom[9]) begin errors++; $display("FAIL stall_rel_inst got %h want %h", o_inst, rom[9]); end
  endtask

  task automatic test_reset_mid();
    sel = 1'b1; clear_mon(); pc = 32'h30; observe(2);
    rst = 1'b0; #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b want 0", o_stall); end
    checks++; if (o_addr !== '0)    begin errors++; $display("FAIL rstmid_addr got %h want 0", o_addr); end
    checks++; if ({o_en, o_valid, o_err} !== 3'b000) begin errors++; $display("FAIL rstmid_pulses got %b want 000", {o_en, o_valid, o_err}); end
    #20; rst = 1'b1;
    clear_mon(); observe(10);
    checks++; if (n_en !== 1)         begin errors++; $display("FAIL rstmid_refetch_count got %0d want 1", n_en); end
    checks++; if (en_addr !== 10'd12) begin errors++; $display("FAIL rstmid_addr_after got %h want c", en_addr); end
    checks++; if (n_valid !== 1)      begin errors++; $display("FAIL rstmid_valid_count got %0d want 1", n_valid); end
    checks++; if (o_inst !== rom[12]) begin errors++; $display("FAIL rstmid_inst got %h want %h", o_inst, rom[12]); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 14; it++) begin
      logic [31:0] p;
      int          ws;
      bit          mis;
      sel = 1'($urandom_range(0, 1));
      ws  = sel ? WS_B : WS_A;
      if ($urandom_range(0, 3) == 0) begin
        ce = 1'b0; observe(1);
        checks++; if (o_inst !== 32'h0) begin errors++; $display("FAIL rnd%0d_ce_off_inst got %h want 0", it, o_inst); end
      end
      mis = ($urandom_range(0, 3) == 0);
      p = $urandom;
      p[1:0] = mis ? 2'($urandom_range(1, 3)) : 2'b00;
      if (p == pc) p = p ^ 32'h100;
      clear_mon(); ce = 1'b1; pc = p; observe(8);
      if (mis) begin
        checks++; if (n_err !== 1 || n_en !== 0 || n_stall !== 0) begin errors++;
          $display("FAIL rnd%0d_mis pc=%h got err=%0d en=%0d stall=%0d want 1/0/0", it, p, n_err, n_en, n_stall); end
        checks++; if (n_valid !== 1 || o_inst !== 32'h0) begin errors++;
          $display("FAIL rnd%0d_mis_inst got valid=%0d inst=%h want 1/0", it, n_valid, o_inst); end
      end else begin
        checks++; if (n_en !== 1 || en_addr !== widx(p)) begin errors++;
          $display("FAIL rnd%0d_req pc=%h got en=%0d addr=%h want 1/%h", it, p, n_en, en_addr, widx(p)); end
        checks++; if (n_stall !== ws + 2) begin errors++;
          $display("FAIL rnd%0d_stall got %0d want %0d", it, n_stall, ws + 2); end
        checks++; if (n_valid !== 1 || o_inst !== rom[widx(p)] || n_err !== 0) begin errors++;
          $display("FAIL rnd%0d_inst got valid=%0d inst=%h err=%0d want 1/%h/0", it, n_valid, o_inst, n_err, rom[widx(p)]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = $urandom | 32'h1;
    rom[0] = 32'h3C011234;
    rst = 1'b0; ce = 1'b0; pc = 32'h0; stall = 6'b0; branch = 1'b0; sel = 1'b0;
    #12;
    test_reset();
    rst = 1'b1;
    test_basic();
    test_hold_pc();
    test_branch_wait();
    test_branch_capture();
    test_misaligned();
    test_stall_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
